// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch front end.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering {pc, instr} entries between fetch and decode.
// Head read is zero when empty so downstream never sees stale storage.
module fetch_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; empty gating on the read side hides its contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses instr_mem and queues {pc, instr}
// toward decode, with start/halt control and flushing redirects.
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned            FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   running
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [ENTRY_W-1:0]    head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= state_next;
  end

  // Halt wins over start; redirects never change the state.
  always_comb begin
    state_next = state;
    if (halt)       state_next = FETCH_HALTED;
    else if (start) state_next = FETCH_RUN;
  end

  always_comb begin
    running  = 1'b0;
    fetch_en = 1'b0;
    if (state == FETCH_RUN) begin
      running  = 1'b1;
      fetch_en = 1'b1;
    end
  end

  assign pop              = ~empty & out_ready;
  assign push             = fetch_en & ~redirect_valid & (~full | pop);
  assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_aligned;
    else if (push)           pc <= pc + ADDR_WIDTH'(INSTR_BYTES);
  end

  assign imem_addr = pc;

  fetch_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc, imem_instr}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_pc    = head[ENTRY_W-1:INSTR_WIDTH];
  assign out_instr = head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized and directed bench for instr_fetch_ctrl against a queue-based fetch model.
module tb_instr_fetch_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, running;

  logic        start2, halt2, redirect_valid2, out_ready2;
  logic [31:0] redirect_pc2;
  logic [31:0] imem_addr2, imem_instr2, out_instr2, out_pc2;
  logic        out_valid2, running2;

  always #5 clk = ~clk;

  assign imem_instr  = imem_addr  ^ 32'hA5A5_0000;
  assign imem_instr2 = imem_addr2 ^ 32'hA5A5_0000;

  instr_fetch_ctrl #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .running(running)
  );

  instr_fetch_ctrl #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RPC2), .FIFO_DEPTH(DEPTH)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .halt(halt2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2), .running(running2)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: pending entries, next fetch address, and mode (0 idle, 1 run, 2 halted).
  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_state;
  int          total  = 0;
  int          passed = 0;
  int          failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = 32'h0;
    m_state = 0;
  endtask

  task automatic check_outputs(input string ph);
    logic [31:0] epc, eins;
    logic        ev;
    ev   = (q.size() != 0);
    epc  = 32'h0;
    eins = 32'h0;
    if (ev) begin
      epc  = q[0].pc;
      eins = q[0].instr;
    end
    check({ph, ":valid"},   32'(out_valid), 32'(ev));
    check({ph, ":pc"},      out_pc, epc);
    check({ph, ":instr"},   out_instr, eins);
    check({ph, ":running"}, 32'(running), 32'(m_state == 1));
    check({ph, ":addr"},    imem_addr, m_pc);
  endtask

  // Applies one clock edge worth of fetch rules to the model.
  task automatic model_update();
    bit do_pop, do_push;
    do_pop = (q.size() != 0) && out_ready;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      do_push = (m_state == 1) && ((q.size() < int'(DEPTH)) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: m_pc ^ 32'hA5A5_0000});
        m_pc = m_pc + 32'd4;
      end
    end
    if (halt)       m_state = 2;
    else if (start) m_state = 1;
  endtask

  task automatic cycle(input string ph);
    check_outputs(ph);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; redirect_valid = 0; redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] got[$];
    int          n;

    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    start2 = 0; halt2 = 0; redirect_valid2 = 0; redirect_pc2 = 32'h0; out_ready2 = 1'b1;
    do_reset();
    check("dut2_reset_addr", imem_addr2, RPC2);
    check("dut2_reset_valid", 32'(out_valid2), 32'h0);

    // Back-to-back streaming
    start = 1; cycle("start");
    start = 0;
    for (int i = 0; i < 10; i++) cycle("stream");

    // Stall with decode not ready until buffer is full, then drain
    do_reset();
    out_ready = 0;
    start = 1; cycle("stall_start");
    start = 0;
    for (int i = 0; i < 7; i++) cycle("stall");
    check("stall_addr_hold", imem_addr, 32'h10);
    check("stall_head_pc", out_pc, 32'h0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) cycle("drain");

    // Redirect with three buffered entries
    do_reset();
    out_ready = 0;
    start = 1; cycle("redir_start");
    start = 0;
    n = 0;
    while (q.size() != 3 && n < 10) begin
      cycle("redir_fill");
      n++;
    end
    check("redir_fill_bound", 32'(q.size()), 32'd3);
    redirect_valid = 1; redirect_pc = 32'h103;
    cycle("redir");
    redirect_valid = 0; redirect_pc = 32'h0;
    out_ready = 1;
    check("redir_flushed", 32'(out_valid), 32'h0);
    for (int i = 0; i < 6; i++) cycle("redir_after");

    // Halt and start together while running, then resume
    out_ready = 0;
    for (int i = 0; i < 2; i++) cycle("hs_fill");
    halt = 1; start = 1; cycle("halt_start");
    halt = 0; start = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) cycle("halted_drain");
    start = 1; cycle("resume");
    start = 0;
    for (int i = 0; i < 5; i++) cycle("resumed");

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      start          = ($urandom_range(0, 7) == 0);
      halt           = ($urandom_range(0, 24) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      out_ready      = ($urandom_range(0, 9) < 7);
      cycle("rand");
    end
    idle_inputs();

    // Reset asserted mid-stream while entries are pending
    out_ready = 0;
    start = 1; cycle("pre_rst");
    start = 0;
    for (int i = 0; i < 3; i++) cycle("pre_rst_fill");
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    model_reset();
    check_outputs("in_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    // PC wrap across the top of the address space on the second instance
    start2 = 1; cycle("wrap_start");
    start2 = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid2 && out_ready2) got.push_back(out_pc2);
      cycle("wrap");
    end
    check("wrap_count_ge3", 32'(got.size() >= 3), 32'h1);
    if (got.size() >= 3) begin
      check("wrap_pc0", got[0], 32'hFFFF_FFF8);
      check("wrap_pc1", got[1], 32'hFFFF_FFFC);
      check("wrap_pc2", got[2], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
